// File: rtl/core_pkg.sv
// Shared types and constants for the core sequencer: state encoding, opcodes, default widths.
package core_pkg;

  localparam int PC_W_DEF    = 8;
  localparam int INSTR_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WB,
    ST_DONE
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_IMM   = 4'b0111;
  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_STORE = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1111;

endpackage

// File: rtl/core_retire_counter.sv
// Saturating 32-bit retired-instruction counter; clear wins over increment, updates one cycle after the event.
module core_retire_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] cnt
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer; min 4 cycles per ALU op, fetch and data waits unbounded.
// Define SEQ_RETIRE_COUNT_EN to add the retire_cnt output and its counter.
module core_sequencer
  import core_pkg::*;
#(
  parameter int             PC_W     = PC_W_DEF,
  parameter int             INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
`ifdef SEQ_RETIRE_COUNT_EN
  output logic [31:0]        retire_cnt,
`endif
  output logic [PC_W-1:0]    pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  input  logic               dec_reg_we,
  input  logic               dec_is_jump,
  output logic               alu_en,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ready,
  output logic               rf_we
);

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               done_q, done_d;
  logic               reg_we_q, reg_we_d;
  logic [PC_W-1:0]    jmp_target;
  logic               is_mem_op;

  assign opcode     = instr_q[INSTR_W-1 -: 4];
  assign jmp_target = instr_q[PC_W-1:0];
  assign is_mem_op  = (opcode == OP_LOAD) || (opcode == OP_STORE);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    done_d   = done_q;
    reg_we_d = reg_we_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          pc_d    = RESET_PC;
          done_d  = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Capture the write flag so rf_we is a clean function of registered state.
        reg_we_d = dec_reg_we;
        state_d  = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (dec_is_jump) begin
          if (jmp_target == pc_q) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            pc_d    = jmp_target;
            state_d = ST_FETCH;
          end
        end else if (is_mem_op) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_ready) begin
          if (opcode == OP_STORE) begin
            pc_d    = pc_q + PC_W'(1);
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      done_q   <= 1'b0;
      reg_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      done_q   <= done_d;
      reg_we_q <= reg_we_d;
    end
  end

  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = done_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign imem_req  = (state_q == ST_FETCH);
  assign imem_addr = pc_q;
  assign alu_en    = (state_q == ST_EXECUTE);
  assign dmem_req  = (state_q == ST_MEM);
  assign dmem_we   = (state_q == ST_MEM) && (opcode == OP_STORE);
  assign rf_we     = (state_q == ST_WB) && reg_we_q;

`ifdef SEQ_RETIRE_COUNT_EN
  logic retire_clr;
  logic retire_inc;

  assign retire_clr = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // Every jump retires in EXECUTE, taken or halting.
  assign retire_inc = (state_q == ST_WB)
                   || ((state_q == ST_MEM) && dmem_ready && (opcode == OP_STORE))
                   || ((state_q == ST_EXECUTE) && dec_is_jump);

  core_retire_counter u_retire_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (retire_clr),
    .inc   (retire_inc),
    .cnt   (retire_cnt)
  );
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized program bench for core_sequencer with an instruction-level reference model.
module tb_core_sequencer;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [7:0]  pc, imem_addr;
  logic        imem_req;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic        dec_reg_we, dec_is_jump;
  logic        alu_en, dmem_req, dmem_we, rf_we;
  logic        dmem_ready = 1'b0;
`ifdef SEQ_RETIRE_COUNT_EN
  logic [31:0] retire_cnt;
`endif

  always #5 clk = ~clk;

  // Stand-in for the core's opcode decoder.
  assign dec_is_jump = (opcode == OP_JMP);
  assign dec_reg_we  = !((opcode == OP_NOP) || (opcode == OP_STORE) || (opcode == OP_JMP));

  core_sequencer #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
`ifdef SEQ_RETIRE_COUNT_EN
    .retire_cnt  (retire_cnt),
`endif
    .pc          (pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .dec_reg_we  (dec_reg_we),
    .dec_is_jump (dec_is_jump),
    .alu_en      (alu_en),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ready  (dmem_ready),
    .rf_we       (rf_we)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] prog [256];

  // Model state for the instruction currently in flight.
  logic [7:0] m_exp_pc, m_halt_pc;
  logic [3:0] m_op;
  bit         m_exp_halt, m_exp_mem, m_exp_we;
  int         m_exp_rf, m_base, m_t0, m_mcyc, m_rfc, m_mw, m_mw0, m_nret;

  function automatic logic [15:0] halt_at(input logic [7:0] a);
    return {OP_JMP, 4'h0, a};
  endfunction

  task automatic fill_halts();
    for (int i = 0; i < 256; i++) prog[i] = halt_at(8'(i));
  endtask

  task automatic gen_prog();
    int n;
    logic [3:0] op;
    logic [7:0] lo;
    fill_halts();
    n = $urandom_range(6, 12);
    for (int a = 0; a < n; a++) begin
      lo = 8'($urandom);
      case ($urandom_range(0, 9))
        0:       op = OP_NOP;
        1:       op = OP_IMM;
        2, 3:    op = 4'($urandom_range(1, 6));
        4, 5:    op = OP_LOAD;
        6, 7:    op = OP_STORE;
        8:       begin op = OP_JMP; lo = 8'(a + $urandom_range(1, 4)); end
        default: op = 4'($urandom_range(10, 14));
      endcase
      prog[a] = {op, 4'($urandom), lo};
    end
    prog[n] = halt_at(8'(n));
  endtask

  task automatic model_decode(input logic [7:0] a, input logic [15:0] ins);
    m_op       = ins[15:12];
    m_exp_halt = 0; m_exp_mem = 0; m_exp_we = 0; m_exp_rf = 0;
    if (m_op == OP_JMP) begin
      m_base = 3;
      if (ins[7:0] == a) begin m_exp_halt = 1; m_halt_pc = a; end
      else m_exp_pc = ins[7:0];
    end else if (m_op == OP_LOAD) begin
      m_exp_mem = 1; m_exp_rf = 1; m_base = 4; m_exp_pc = a + 8'd1;
    end else if (m_op == OP_STORE) begin
      m_exp_mem = 1; m_exp_we = 1; m_base = 3; m_exp_pc = a + 8'd1;
    end else begin
      m_exp_rf = (m_op != OP_NOP) ? 1 : 0; m_base = 4; m_exp_pc = a + 8'd1;
    end
  endtask

  task automatic finalize(input bit halted, input int cyc);
    chk("halt_kind", 32'(halted), 32'(m_exp_halt));
    chk("rf_we_pulses", m_rfc, m_exp_rf);
    chk("mem_cycles", m_mcyc, m_exp_mem ? m_mw0 + 1 : 0);
    chk("instr_cycles", cyc - m_t0, m_base + (m_exp_mem ? m_mw0 + 1 : 0));
    m_nret++;
  endtask

  function automatic int pick(input int w);
    return (w < 0) ? int'($urandom_range(0, 3)) : w;
  endfunction

  // fwait/mwait < 0 selects random wait states per access.
  task automatic run_prog(input int fwait, input int mwait, input bit wrap, input int max_cyc);
    bit pending = 0, in_fetch = 0, got_done = 0;
    int fw = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_clears_done", 32'(done), 0);
    chk("start_busy", 32'(busy), 1);
`ifdef SEQ_RETIRE_COUNT_EN
    chk("start_clears_retire", retire_cnt, 0);
`endif
    m_exp_pc = 8'h00; m_nret = 0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      if (imem_req) begin
        if (!in_fetch) begin
          if (pending) finalize(0, cyc);
          chk("fetch_addr", 32'(imem_addr), 32'(m_exp_pc));
          in_fetch = 1; fw = pick(fwait);
        end
        if (fw == 0) begin
          imem_valid = 1'b1;
          imem_rdata = prog[imem_addr];
          model_decode(imem_addr, prog[imem_addr]);
          if (wrap && imem_addr == 8'h00) prog[0] = halt_at(8'h00);
          m_t0 = cyc; pending = 1; in_fetch = 0;
          m_mcyc = 0; m_rfc = 0; m_mw = pick(mwait); m_mw0 = m_mw;
        end else begin
          imem_valid = 1'b0; imem_rdata = 16'($urandom); fw--;
        end
      end else begin
        imem_valid = 1'($urandom); imem_rdata = 16'($urandom);
      end
      if (alu_en) chk("exec_opcode", 32'(opcode), 32'(m_op));
      if (dmem_req) begin
        if (m_mcyc == 0) chk("dmem_we", 32'(dmem_we), 32'(m_exp_we));
        m_mcyc++;
        if (m_mw == 0) dmem_ready = 1'b1;
        else begin dmem_ready = 1'b0; m_mw--; end
      end else begin
        dmem_ready = 1'($urandom);
      end
      if (rf_we) m_rfc++;
      if (done) begin
        finalize(1, cyc);
        chk("halt_pc", 32'(pc), 32'(m_halt_pc));
        chk("halt_busy", 32'(busy), 0);
`ifdef SEQ_RETIRE_COUNT_EN
        chk("retire_cnt", retire_cnt, m_nret);
`endif
        got_done = 1;
        break;
      end
      start = busy && ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    if (!got_done) chk("run_timeout", 0, 1);
    start = 1'b0; imem_valid = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic reset_mid_mem();
    bit reached = 0;
    fill_halts();
    prog[0]     = halt_at(8'h10) & 16'hF0FF;
    prog[0]     = {OP_JMP, 4'h0, 8'h10};
    prog[8'h10] = {OP_LOAD, 12'h034};
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    dmem_ready = 1'b0;
    for (int c = 0; c < 40 && !reached; c++) begin
      imem_valid = imem_req; imem_rdata = prog[imem_addr];
      if (dmem_req) reached = 1;
      else @(negedge clk);
    end
    chk("reached_mem", 32'(reached), 1);
    repeat (2) @(negedge clk);
    chk("mem_held", 32'(dmem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_strobes", {imem_req, alu_en, dmem_req, dmem_we, rf_we}, 0);
    chk("arst_busy_done", {busy, done}, 0);
    chk("arst_pc", 32'(pc), 0);
    chk("arst_instr", 32'(instr), 0);
    @(negedge clk); rst_n = 1'b1; imem_valid = 1'b0;
    @(negedge clk);
    chk("post_arst_idle", {busy, imem_req, dmem_req}, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_strobes", {imem_req, alu_en, dmem_req, dmem_we, rf_we}, 0);
    chk("reset_busy_done", {busy, done}, 0);
    chk("reset_pc", 32'(pc), 0);
    chk("reset_instr", 32'(instr), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_start", {busy, imem_req}, 0);

    fill_halts();
    prog[0] = {OP_NOP, 12'h000};
    prog[1] = {4'b0010, 12'h345};
    prog[2] = halt_at(8'h02);
    run_prog(0, 0, 0, 200);

    fill_halts();
    prog[0] = {OP_NOP, 12'h000};
    prog[1] = {4'b0010, 12'h111};
    prog[2] = {OP_IMM, 12'h222};
    prog[3] = {OP_LOAD, 12'h0AB};
    prog[4] = {OP_STORE, 12'h0CD};
    prog[5] = halt_at(8'h05);
    run_prog(0, 3, 0, 200);

    fill_halts();
    prog[0]     = {OP_JMP, 4'h0, 8'hFF};
    prog[8'hFF] = {4'b0010, 12'h777};
    run_prog(1, 0, 1, 200);

    reset_mid_mem();

    for (int r = 0; r < 25; r++) begin
      gen_prog();
      run_prog(-1, -1, 0, 3000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
